iter_divider: RTL and testbench
===============================

Name: iter_divider

Overview:
- Multi-cycle RV32M divide/remainder unit (DIV, DIVU, REM, REMU) for the sail-core execute stage.
- Drives the core's 32-bit DSP subtractor as its trial-subtract datapath: it feeds the subtractor's operands and consumes its difference and carry.
- Restoring division, one quotient bit per cycle.
- Valid/busy handshake to the pipeline; one-cycle done pulse with the result.

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported, because it must match the subtractor.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- kill  input  1  pipeline flush; aborts any operation in flight
- op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- dividend  input  32  rs1 value
- divisor  input  32  rs2 value
- busy  output  1  high from the accepting edge until done
- done  output  1  one-cycle pulse; result is valid this cycle
- result  output  32  quotient or remainder; holds its value until the next done
- sub_in1  output  32  minuend to the external subtractor
- sub_in2  output  32  subtrahend to the external subtractor
- sub_diff  input  32  sub_in1 - sub_in2, combinational
- sub_carry  input  1  1 when sub_in1 >= sub_in2 unsigned (no borrow), combinational

Behaviour:
- Reset (synchronous, any state): state IDLE; busy=0, done=0, result=0, sub_in1=0, sub_in2=0; counter and internal registers cleared.
- States: IDLE, SETUP, ITER, FIX, SPECIAL.
- IDLE:
  - start=1 and kill=0 at an edge: capture op/dividend/divisor and set busy=1.
  - Divide-by-zero or signed overflow (op DIV/REM, dividend 0x80000000, divisor 0xFFFFFFFF) -> SPECIAL; otherwise -> SETUP.
- SETUP (1 cycle):
  - For signed ops, form |dividend| and |divisor| internally (the subtractor is not used).
  - Record quotient sign = sign(dividend) XOR sign(divisor); remainder sign = sign(dividend).
  - Clear the partial remainder R (32 bits) and the counter -> ITER.
- ITER (exactly 32 cycles, counter 0..31):
  - Shifted value S = {R[30:0], next dividend MSB}; bit-out ob = R[31].
  - Drive sub_in1=S and sub_in2=|divisor|.
  - If ob=1 or sub_carry=1: R<=sub_diff and quotient bit=1; else R<=S and quotient bit=0.
  - The ob path covers divisors >= 2^31 correctly.
  - Counter wraps from 31 -> FIX.
- FIX (1 cycle):
  - Negate the quotient if its sign bit is set (DIV); negate the remainder if its sign bit is set (REM).
  - Load result, pulse done=1 in the following cycle, busy=0, -> IDLE.
- SPECIAL (1 cycle):
  - Divide-by-zero: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> dividend.
  - Overflow: DIV -> 0x80000000; REM -> 0.
  - Load result, then done/busy as in FIX.
- Latency from the accepting edge to done: normal 34 cycles (SETUP 1 + ITER 32 + FIX 1); special 1 cycle.
- When not in ITER: sub_in1=sub_in2=0.
- start while busy=1: ignored, with no queuing.
- A new start may be accepted in the same cycle done=1, because busy is already 0.
- kill=1 at any edge: -> IDLE next edge; busy=0; no done; result unchanged.
- kill wins over a simultaneous start.
- done is never asserted for an aborted operation.
- rst mid-operation: same as kill, and result is cleared to 0.

Decomposition:
- Shared package (sail-core divider package):
  - op encoding constants (OP_DIV, OP_DIVU, OP_REM, OP_REMU);
  - state encoding for IDLE/SETUP/ITER/FIX/SPECIAL;
  - constants ITER_COUNT=32, INT_MIN=0x80000000, ALL_ONES=0xFFFFFFFF.
- No sub-module. The subtractor stays outside the block and is wired at the execute-stage level through the sub_* ports.

Test Plan:
- DIVU 100/7 -> result 14, done at 34 cycles, busy high 34 cycles; REMU 100/7 -> 2.
- DIV -7/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); REM 7/-2 -> 1.
- DIVU 0xFFFFFFFF/0x80000001 -> 1; REMU -> 0x7FFFFFFE (exercises the ob path).
- DIV 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0; all of these give done 1 cycle after start.
- kill asserted at ITER count 10 -> busy=0 next cycle, no done pulse, result unchanged. rst at count 20 -> result=0, busy=0. A following DIVU 9/3 -> 3.
- start pulsed while busy -> ignored, first result only. Back-to-back start in the done cycle -> accepted, second done 34 cycles later.

Source files
------------

// File: rtl/iter_divider_pkg.sv
// Shared definitions for the sail-core RV32M divide/remainder unit.
// Holds the op encoding, the FSM state encoding and the fixed constants.
package iter_divider_pkg;

  // op[1] selects remainder, op[0] selects unsigned
  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  localparam int          ITER_COUNT = 32;
  localparam logic [31:0] INT_MIN    = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES   = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_ITER    = 3'd2,
    ST_FIX     = 3'd3,
    ST_SPECIAL = 3'd4
  } div_state_e;

  // Magnitude of a two's complement value when the op is signed.
  function automatic logic [31:0] abs_if_signed(input logic is_signed, input logic [31:0] v);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/iter_divider.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Latency: 34 cycles from the accepting edge to done (1 cycle for div-by-zero / overflow).
// Backpressure: start is taken only while busy=0; kill or rst abort with no done pulse.
module iter_divider
  import iter_divider_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             kill,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] sub_in1,
  output logic [WIDTH-1:0] sub_in2,
  input  logic [WIDTH-1:0] sub_diff,
  input  logic             sub_carry
);

  div_state_e       state_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] dvd_q;     // dividend, shifted out MSB-first; quotient bits shift in
  logic [WIDTH-1:0] dvs_q;     // divisor magnitude after SETUP
  logic [WIDTH-1:0] rem_q;     // partial remainder R
  logic [4:0]       cnt_q;
  logic             qneg_q;
  logic             rneg_q;
  logic             div0_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;

  logic [WIDTH-1:0] shift_d;
  logic             take_d;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] dvd_d;
  logic [WIDTH-1:0] fix_d;
  logic [WIDTH-1:0] special_d;
  logic             in_div0;
  logic             in_ovf;

  // Trial-subtract step, sign fix-up and special-case result selection
  always_comb begin
    shift_d = {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
    // A set bit-out means the true shifted value is >= 2^32 and always exceeds the divisor
    take_d  = rem_q[WIDTH-1] | sub_carry;
    rem_d   = take_d ? sub_diff : shift_d;
    dvd_d   = {dvd_q[WIDTH-2:0], take_d};
    fix_d   = dvd_q;
    if (op_q[1]) begin
      fix_d = rneg_q ? (~rem_q + 32'd1) : rem_q;
    end else if (qneg_q) begin
      fix_d = ~dvd_q + 32'd1;
    end
    special_d = '0;
    if (div0_q) begin
      special_d = op_q[1] ? dvd_q : ALL_ONES;
    end else if (!op_q[1]) begin
      special_d = INT_MIN;
    end
    in_div0 = (divisor == '0);
    in_ovf  = !op[0] && (dividend == INT_MIN) && (divisor == ALL_ONES);
  end

  assign sub_in1 = (state_q == ST_ITER) ? shift_d : '0;
  assign sub_in2 = (state_q == ST_ITER) ? dvs_q   : '0;
  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = result_q;

  // Control FSM with registered busy/done/result; kill aborts without touching result
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else if (kill) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            op_q    <= op;
            dvd_q   <= dividend;
            dvs_q   <= divisor;
            div0_q  <= in_div0;
            busy_q  <= 1'b1;
            state_q <= (in_div0 || in_ovf) ? ST_SPECIAL : ST_SETUP;
          end
        end
        ST_SETUP: begin
          dvd_q   <= abs_if_signed(!op_q[0], dvd_q);
          dvs_q   <= abs_if_signed(!op_q[0], dvs_q);
          qneg_q  <= !op_q[0] && (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
          rneg_q  <= !op_q[0] && dvd_q[WIDTH-1];
          rem_q   <= '0;
          cnt_q   <= '0;
          state_q <= ST_ITER;
        end
        ST_ITER: begin
          rem_q <= rem_d;
          dvd_q <= dvd_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'(ITER_COUNT - 1)) begin
            state_q <= ST_FIX;
          end
        end
        ST_FIX: begin
          result_q <= fix_d;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end
        ST_SPECIAL: begin
          result_q <= special_d;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
// Self-checking bench for iter_divider: directed corner cases plus random ops
// against a plain-arithmetic RV32M reference, with an ideal subtractor model.
module tb_iter_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [31:0] sub_in1;
  logic [31:0] sub_in2;
  logic [31:0] sub_diff;
  logic        sub_carry;

  int errors = 0;
  int checks = 0;
  logic [31:0] last_res = '0;

  always #5 clk = ~clk;

  // Ideal external DSP subtractor
  assign sub_diff  = sub_in1 - sub_in2;
  assign sub_carry = (sub_in1 >= sub_in2);

  iter_divider #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .kill     (kill),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .sub_in1  (sub_in1),
    .sub_in2  (sub_in2),
    .sub_diff (sub_diff),
    .sub_carry(sub_carry)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // RV32M semantics from the ISA rules, using native integer division
  function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
      sa = a;
      sb = b;
      return o[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return o[1] ? (a % b) : (a / b);
  endfunction

  function automatic int ref_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Present a request and let one edge accept it
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o;
    dividend = a;
    divisor = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Called #1 after the accepting edge; returns #1 after the edge that raised done
  task automatic wait_done(input string tag, input logic [31:0] exp_res, input int exp_lat);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    check({tag, ".busy_acc"}, {31'd0, busy}, 32'd1);
    while (n < 100 && !got) begin
      @(posedge clk);
      #1;
      n++;
      if (done) got = 1'b1;
    end
    check({tag, ".done_seen"}, {31'd0, got}, 32'd1);
    check({tag, ".latency"}, n, exp_lat);
    check({tag, ".result"}, result, exp_res);
    check({tag, ".busy_done"}, {31'd0, busy}, 32'd0);
    if (got) last_res = exp_res;
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    issue(o, a, b);
    wait_done(tag, ref_div(o, a, b), ref_lat(o, a, b));
    @(posedge clk);
    #1;
    check({tag, ".pulse"}, {31'd0, done}, 32'd0);
    check({tag, ".hold"}, result, ref_div(o, a, b));
  endtask

  // Watch a window of cycles and return how many done pulses were seen
  task automatic count_done(input int cycles, output int seen);
    seen = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
  endtask

  initial begin
    int seen;
    logic [1:0] ro;
    logic [31:0] ra;
    logic [31:0] rb;

    repeat (3) @(posedge clk);
    #1;
    check("rst.busy", {31'd0, busy}, 32'd0);
    check("rst.done", {31'd0, done}, 32'd0);
    check("rst.result", result, 32'd0);
    check("rst.sub_in1", sub_in1, 32'd0);
    check("rst.sub_in2", sub_in2, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_op("divu_100_7", 2'b01, 32'd100, 32'd7);
    run_op("remu_100_7", 2'b11, 32'd100, 32'd7);
    run_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2);
    run_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2);
    run_op("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE);
    run_op("divu_ob", 2'b01, 32'hFFFF_FFFF, 32'h8000_0001);
    run_op("remu_ob", 2'b11, 32'hFFFF_FFFF, 32'h8000_0001);
    run_op("div_by0", 2'b00, 32'd5, 32'd0);
    run_op("remu_by0", 2'b11, 32'd5, 32'd0);
    run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);

    // Kill at ITER count 10: SETUP takes one edge, ITER count 10 follows 10 more
    issue(2'b01, 32'd1000, 32'd3);
    repeat (11) @(posedge clk);
    #1;
    check("kill.sub_in2", sub_in2, 32'd3);
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    check("kill.busy", {31'd0, busy}, 32'd0);
    count_done(40, seen);
    check("kill.no_done", seen, 32'd0);
    check("kill.result", result, last_res);
    check("kill.sub_in1", sub_in1, 32'd0);

    // Reset at ITER count 20 clears the result
    issue(2'b00, 32'd12345, 32'd17);
    repeat (21) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst.busy", {31'd0, busy}, 32'd0);
    check("midrst.result", result, 32'd0);
    count_done(40, seen);
    check("midrst.no_done", seen, 32'd0);
    last_res = 32'd0;
    run_op("divu_9_3", 2'b01, 32'd9, 32'd3);

    // Start while busy is ignored and not queued
    issue(2'b01, 32'd50, 32'd5);
    repeat (5) @(posedge clk);
    #1;
    op = 2'b11;
    dividend = 32'd77;
    divisor = 32'd10;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("ign.busy", {31'd0, busy}, 32'd1);
    count_done(40, seen);
    check("ign.one_done", seen, 32'd1);
    check("ign.result", result, 32'd10);
    last_res = 32'd10;

    // Back-to-back: second request issued in the done cycle
    issue(2'b01, 32'd200, 32'd9);
    wait_done("b2b_a", 32'd22, 34);
    issue(2'b10, 32'hFFFF_FF9C, 32'd7);
    wait_done("b2b_b", 32'hFFFF_FFFE, 34);

    // Random ops against the reference model
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin rb = 32'hFFFF_FFFF; if ($urandom_range(0, 1) == 1) ra = 32'h8000_0000; end
        2: rb = 32'($urandom_range(1, 15));
        3: rb = 32'h8000_0000 | $urandom;
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      run_op($sformatf("rnd%0d", i), ro, ra, rb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
